// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Front-end fetch stage. Holds the program counter and a loadable
//            instruction memory, and presents one instruction per cycle
//            through a registered IF/ID output. Handles decode stalls,
//            taken-branch redirects (one bubble per redirect) and a HALT
//            opcode that freezes fetch until reset.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous active-low reset
//            prog_we    - memory write enable (IDLE only)
//            prog_addr  - memory write address
//            prog_data  - memory write data
//            start      - leave IDLE, fetch from PC 0 (IDLE only)
//            stall      - hold PC and IF/ID register
//            br_taken   - redirect to br_target, flush IF/ID
//            br_target  - redirect address
//            ins        - IF/ID instruction (0 when bubble)
//            pc_out     - address of the instruction on ins
//            ins_valid  - ins holds a real instruction
//            halted     - fetch frozen by HALT
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int          AW      = 8,
  parameter int          IW      = 24,
  parameter logic [4:0]  HALT_OP = 5'b11111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [IW-1:0] ins,
  output logic [AW-1:0] pc_out,
  output logic          ins_valid,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [AW-1:0] C_PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ins_q, ins_d;
  logic [AW-1:0] pc_out_q, pc_out_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;

  logic [IW-1:0] mem_q [0:(1<<AW)-1];
  logic [IW-1:0] w_word;
  logic          w_is_halt;

  // Memory has no reset so a loaded program survives a reset pulse.
  // Writes are blocked outside IDLE and while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_IDLE) && prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign w_word    = mem_q[pc_q];
  assign w_is_halt = (w_word[IW-1 -: 5] == HALT_OP);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (br_taken) begin
          // Flush: the slot after a redirect is always a bubble.
          pc_d    = br_target;
          ins_d   = '0;
          valid_d = 1'b0;
        end else if (!stall) begin
          ins_d    = w_word;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          if (w_is_halt) begin
            // HALT word is issued once; PC parks on it.
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + C_PC_ONE;
          end
        end
      end
      S_HALT: begin
        ins_d    = '0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ins_q    <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign ins       = ins_q;
  assign pc_out    = pc_out_q;
  assign ins_valid = valid_q;
  assign halted    = halted_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end pipeline stage directly upstream of the dependency check / decode stage.
- Holds the program counter and a loadable instruction memory.
- Presents one 24-bit instruction per cycle through a registered IF/ID output.
- Handles stall, taken-branch redirect with bubble insertion, and a HALT opcode that freezes fetch until reset.

Parameters:
- AW, 8, PC / instruction-memory address width; memory depth = 2^AW words.
- IW, 24, instruction width; opcode = ins[IW-1:IW-5].
- HALT_OP, 5'b11111, opcode that stops fetch.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- prog_we  input  1  instruction-memory write enable; honoured only in IDLE.
- prog_addr  input  AW  write address.
- prog_data  input  IW  write data.
- start  input  1  leave IDLE and begin fetching at PC 0; honoured only in IDLE.
- stall  input  1  hold PC and IF/ID register (hazard stall from decode).
- br_taken  input  1  redirect fetch to br_target and flush the IF/ID register.
- br_target  input  AW  redirect address.
- ins  output  IW  IF/ID instruction to the dependency check stage.
- pc_out  output  AW  address of the instruction currently on ins.
- ins_valid  output  1  ins holds a real instruction (0 = bubble).
- halted  output  1  fetch frozen by HALT.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, pc=0, ins=0, pc_out=0, ins_valid=0, halted=0. Memory contents are retained. Reset has priority over every other input, including mid-RUN and in HALT.
- Bubble = ins 24'h000000 with ins_valid=0. Downstream treats it as a NOP.
- FSM states: IDLE, RUN, HALT.
- IDLE behaviour:
  - prog_we=1 writes mem[prog_addr]=prog_data at the edge.
  - Outputs hold their reset values.
  - start=1 -> RUN with pc=0. A start and prog_we in the same cycle: the write completes, then RUN.
- RUN, priority is br_taken > stall > normal fetch:
  - br_taken=1: pc<=br_target, ins<=0, ins_valid<=0. The flushed slot appears on the next cycle; br_target is fetched the cycle after.
  - stall=1 (br_taken=0): pc, ins, pc_out, ins_valid all hold.
  - Normal fetch: ins<=mem[pc], pc_out<=pc, ins_valid<=1, pc<=pc+1 modulo 2^AW (wraps 2^AW-1 -> 0, no flag).
  - Fetch latency: 1 cycle from pc to ins.
- HALT entry:
  - On a normal fetch where mem[pc][IW-1:IW-5]==HALT_OP, the HALT word is issued (ins_valid=1) and pc does not increment; state -> HALT.
  - If br_taken is asserted in that cycle, the halt word is discarded (branch wins) and the state stays RUN.
  - A stall in that cycle delays HALT entry.
- In HALT:
  - Next edge: ins<=0, ins_valid<=0, halted<=1. These hold thereafter.
  - stall, br_taken, start and prog_we are ignored. Exit is by reset only.
- prog_we in RUN or HALT: ignored, memory unchanged.
- Read and write addresses never coincide, because writes happen only in IDLE and reads only in RUN.

Test Plan:
- Reset, program load and straight-line fetch:
  - Hold reset=0 for 2 cycles, then reset=1.
  - Write mem[0]=24'h000230, mem[1]=24'hA41000, mem[2]=24'h285040.
  - Pulse start.
  - Required: ins=24'h000230/pc_out=0, then 24'hA41000/1, then 24'h285040/2 on consecutive cycles, with ins_valid=1 throughout.
- Stall hold:
  - Assert stall for 3 cycles while ins=24'hA41000, pc_out=1.
  - Required: ins, pc_out and ins_valid unchanged for those 3 cycles. Release stall; the next ins is from mem[2].
- Branch redirect:
  - Load mem[5]=24'h6C1050. Assert br_taken with br_target=5 for 1 cycle.
  - Required: the next cycle shows ins=0, ins_valid=0. The following cycle shows ins=24'h6C1050, pc_out=5.
  - Repeat with stall=1 in the same cycle; br_taken must still win.
- HALT:
  - Load mem[3]=24'hF80000 and run from 0.
  - Required: mem[3] is issued with ins_valid=1. The next cycle has halted=1, ins=0, ins_valid=0.
  - These stay stable for 10 cycles despite br_taken=1 and start=1 pulses.
  - A prog_we attempt to address 0 is ignored, checked after reset plus a re-run.
- PC wrap:
  - Fill mem[254]=24'h111111, mem[255]=24'h222222, mem[0]=24'h333333. Branch to 254.
  - Required: pc_out sequence 254, 255, 0 with the matching words.
- Reset mid-operation:
  - Assert reset=0 for 1 cycle during RUN at pc_out=2.
  - Required: the next cycle has ins=0, ins_valid=0, pc_out=0 and state IDLE (no fetch until start).
  - Memory still holds the loaded program.
